pc_ir_unit: RTL and testbench

//  Program-counter, instruction-register and ALU-result holding stage of the multicycle CPU.

---
 rtl/cpu_pkg.sv | 23 ++
 rtl/pc_ir_unit_en_reg.sv | 20 ++
 rtl/pc_ir_unit.sv | 86 ++++++++
 tb/tb_pc_ir_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcode encodings and instruction-register field positions.
package cpu_pkg;

   localparam logic [5:0] OP_NOP = 6'b000000;
   localparam logic [5:0] OP_J   = 6'b000010;
   localparam logic [5:0] OP_BEQ = 6'b000100;
   localparam logic [5:0] OP_BNE = 6'b000101;
   localparam logic [5:0] OP_LWI = 6'b100001;
   localparam logic [5:0] OP_SWI = 6'b101001;
   localparam logic [5:0] OP_LI  = 6'b001111;

   localparam int OP_MSB  = 31;
   localparam int OP_LSB  = 26;
   localparam int RS_MSB  = 25;
   localparam int RS_LSB  = 21;
   localparam int RT_MSB  = 20;
   localparam int RT_LSB  = 16;
   localparam int RD_MSB  = 15;
   localparam int RD_LSB  = 11;
   localparam int IMM_MSB = 15;
   localparam int JMP_MSB = 25;

endpackage

// File: rtl/pc_ir_unit_en_reg.sv
// Register with load enable and asynchronous reset to a parameterised value.
module en_reg #(
   parameter int           W   = 32,
   parameter logic [W-1:0] RST = '0
) (
   input  logic         Clk,
   input  logic         Reset,
   input  logic         en,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset)
         q <= RST;
      else if (en)
         q <= d;
   end

endmodule

// File: rtl/pc_ir_unit.sv
// PC / IR / ALU-result holding stage of the multicycle CPU; branch resolution
// happens here, sequencing is left entirely to the control FSM.
module pc_ir_unit
   import cpu_pkg::*;
#(
   parameter int DW       = 32,
   parameter int PCW      = 16,
   parameter int RESET_PC = 0,
   parameter int CNTW     = 16
) (
   input  logic            Clk,
   input  logic            Reset,
   input  logic            PCSource,
   input  logic            PCWrite,
   input  logic            BEQcontrol,
   input  logic            BNEcontrol,
   input  logic            IRWrite,
   input  logic [31:0]     InstrData,
   input  logic [DW-1:0]   AluResult,
   input  logic            AluZero,
   output logic [PCW-1:0]  PC,
   output logic [31:0]     IR,
   output logic [5:0]      Opcode,
   output logic [4:0]      Rs,
   output logic [4:0]      Rt,
   output logic [4:0]      Rd,
   output logic [15:0]     Imm16,
   output logic [DW-1:0]   ImmSE,
   output logic [25:0]     JumpField,
   output logic [DW-1:0]   AluOut,
   output logic            BranchTaken,
   output logic [CNTW-1:0] InstrCount,
   output logic            CtrlErr
);

   logic           br_take;
   logic           pc_en;
   logic [PCW-1:0] pc_next;

   assign br_take = (BEQcontrol & AluZero) | (BNEcontrol & ~AluZero);
   assign pc_en   = PCWrite | br_take;
   // AluOut is the pre-edge value, so a target latched at decode survives the compare cycle
   assign pc_next = PCSource ? AluOut[PCW-1:0] : AluResult[PCW-1:0];

   en_reg #(.W(PCW), .RST(PCW'(RESET_PC))) u_pc (
      .Clk   (Clk),
      .Reset (Reset),
      .en    (pc_en),
      .d     (pc_next),
      .q     (PC)
   );

   en_reg #(.W(32), .RST(32'd0)) u_ir (
      .Clk   (Clk),
      .Reset (Reset),
      .en    (IRWrite),
      .d     (InstrData),
      .q     (IR)
   );

   assign Opcode    = IR[OP_MSB:OP_LSB];
   assign Rs        = IR[RS_MSB:RS_LSB];
   assign Rt        = IR[RT_MSB:RT_LSB];
   assign Rd        = IR[RD_MSB:RD_LSB];
   assign Imm16     = IR[IMM_MSB:0];
   assign ImmSE     = {{(DW-16){IR[IMM_MSB]}}, IR[IMM_MSB:0]};
   assign JumpField = IR[JMP_MSB:0];

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         AluOut      <= '0;
         BranchTaken <= 1'b0;
         InstrCount  <= '0;
         CtrlErr     <= 1'b0;
      end else begin
         AluOut      <= AluResult;
         // an unconditional write alongside a branch is a jump, not a taken branch
         BranchTaken <= br_take & ~PCWrite;
         if (IRWrite)
            InstrCount <= InstrCount + CNTW'(1);
         if (BEQcontrol & BNEcontrol)
            CtrlErr <= 1'b1;
      end
   end

endmodule

// File: tb/tb_pc_ir_unit.sv
// Directed plus random checks of pc_ir_unit against a cycle-level behavioural model.
module tb_pc_ir_unit;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        PCSource, PCWrite, BEQcontrol, BNEcontrol, IRWrite, AluZero;
   logic [31:0] InstrData, AluResult;
   logic [15:0] PC;
   logic [31:0] IR;
   logic [5:0]  Opcode;
   logic [4:0]  Rs, Rt, Rd;
   logic [15:0] Imm16;
   logic [31:0] ImmSE;
   logic [25:0] JumpField;
   logic [31:0] AluOut;
   logic        BranchTaken;
   logic [15:0] InstrCount;
   logic        CtrlErr;

   int errors = 0;
   int checks = 0;

   // behavioural model state
   int unsigned m_pc, m_ir, m_aluout, m_cnt;
   bit          m_bt, m_err;

   pc_ir_unit dut (
      .Clk(Clk), .Reset(Reset), .PCSource(PCSource), .PCWrite(PCWrite),
      .BEQcontrol(BEQcontrol), .BNEcontrol(BNEcontrol), .IRWrite(IRWrite),
      .InstrData(InstrData), .AluResult(AluResult), .AluZero(AluZero),
      .PC(PC), .IR(IR), .Opcode(Opcode), .Rs(Rs), .Rt(Rt), .Rd(Rd),
      .Imm16(Imm16), .ImmSE(ImmSE), .JumpField(JumpField), .AluOut(AluOut),
      .BranchTaken(BranchTaken), .InstrCount(InstrCount), .CtrlErr(CtrlErr)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_pc = 0; m_ir = 0; m_aluout = 0; m_cnt = 0; m_bt = 0; m_err = 0;
   endtask

   task automatic idle_inputs();
      PCSource = 0; PCWrite = 0; BEQcontrol = 0; BNEcontrol = 0; IRWrite = 0; AluZero = 0;
   endtask

   task automatic check_all(input string tag);
      int unsigned imm, immse;
      imm   = m_ir % 65536;
      immse = (imm >= 32768) ? imm + 32'hFFFF_0000 : imm;
      check({tag, ".PC"},         64'(PC),          64'(m_pc));
      check({tag, ".IR"},         64'(IR),          64'(m_ir));
      check({tag, ".Opcode"},     64'(Opcode),      64'(m_ir / (1 << 26)));
      check({tag, ".Rs"},         64'(Rs),          64'((m_ir / (1 << 21)) % 32));
      check({tag, ".Rt"},         64'(Rt),          64'((m_ir / (1 << 16)) % 32));
      check({tag, ".Rd"},         64'(Rd),          64'((m_ir / (1 << 11)) % 32));
      check({tag, ".Imm16"},      64'(Imm16),       64'(imm));
      check({tag, ".ImmSE"},      64'(ImmSE),       64'(immse));
      check({tag, ".JumpField"},  64'(JumpField),   64'(m_ir % (1 << 26)));
      check({tag, ".AluOut"},     64'(AluOut),      64'(m_aluout));
      check({tag, ".BranchTaken"},64'(BranchTaken), 64'(m_bt));
      check({tag, ".InstrCount"}, 64'(InstrCount),  64'(m_cnt));
      check({tag, ".CtrlErr"},    64'(CtrlErr),     64'(m_err));
   endtask

   // one clock edge: model advances from pre-edge inputs, outputs checked on the falling edge
   task automatic cyc(input string tag);
      bit take;
      int unsigned nxt_pc;
      take   = (BEQcontrol && AluZero) || (BNEcontrol && !AluZero);
      nxt_pc = PCSource ? (m_aluout % 65536) : (AluResult % 65536);
      @(posedge Clk);
      if (PCWrite || take) m_pc = nxt_pc;
      if (IRWrite) begin
         m_ir  = InstrData;
         m_cnt = (m_cnt + 1) % 65536;
      end
      m_bt      = take && !PCWrite;
      if (BEQcontrol && BNEcontrol) m_err = 1;
      m_aluout  = AluResult;
      @(negedge Clk);
      check_all(tag);
      $display("%t %s: PC=%h IR=%h AluOut=%h BT=%0d Cnt=%0d Err=%0d",
               $time, tag, PC, IR, AluOut, BranchTaken, InstrCount, CtrlErr);
   endtask

   initial begin
      idle_inputs();
      InstrData = 0; AluResult = 32'h1234_5678;
      Reset = 1'b1;
      model_reset();
      #2;
      check_all("reset_no_edge");
      @(negedge Clk); @(negedge Clk);
      Reset = 1'b0;
      AluResult = 0;
      cyc("idle");

      // fetch
      InstrData = 32'h8400_FFFB; IRWrite = 1; PCWrite = 1; PCSource = 0; AluResult = 1;
      cyc("fetch");
      check("fetch.PC_const",     64'(PC),     64'h1);
      check("fetch.Opcode_const", 64'(Opcode), 64'b100001);
      check("fetch.ImmSE_const",  64'(ImmSE),  64'hFFFF_FFFB);

      // BEQ taken then not taken
      idle_inputs(); AluResult = 32'h10;
      cyc("beq_tgt");
      BEQcontrol = 1; PCSource = 1; AluZero = 1; AluResult = 32'h99;
      cyc("beq_taken");
      check("beq_taken.PC_const", 64'(PC), 64'h10);
      check("beq_taken.BT_const", 64'(BranchTaken), 64'h1);
      idle_inputs(); AluResult = 32'h30;
      cyc("beq_after");
      BEQcontrol = 1; PCSource = 1; AluZero = 0; AluResult = 32'h77;
      cyc("beq_not_taken");

      // BNE taken then held
      idle_inputs(); AluResult = 32'h20;
      cyc("bne_tgt");
      BNEcontrol = 1; PCSource = 1; AluZero = 0;
      cyc("bne_taken");
      check("bne_taken.PC_const", 64'(PC), 64'h20);
      idle_inputs(); AluResult = 32'h28;
      cyc("bne_tgt2");
      BNEcontrol = 1; PCSource = 1; AluZero = 1;
      cyc("bne_not_taken");

      // jump with a branch strobe present, then PC wrap
      idle_inputs(); AluResult = 32'h3A;
      cyc("jmp_tgt");
      PCSource = 1; PCWrite = 1; BEQcontrol = 1; AluZero = 0;
      cyc("jump");
      check("jump.PC_const", 64'(PC), 64'h3A);
      idle_inputs(); PCWrite = 1; AluResult = 32'hFFFF;
      cyc("pc_ffff");
      AluResult = 32'h1_0000;
      cyc("pc_wrap");
      check("pc_wrap.PC_const", 64'(PC), 64'h0);

      // random traffic, illegal BEQ+BNE excluded here
      for (int i = 0; i < 150; i++) begin
         PCSource   = 1'($urandom);
         PCWrite    = ($urandom_range(0, 3) == 0);
         IRWrite    = 1'($urandom);
         AluZero    = 1'($urandom);
         InstrData  = $urandom;
         AluResult  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 255));
         case ($urandom_range(0, 2))
            0: begin BEQcontrol = 1; BNEcontrol = 0; end
            1: begin BEQcontrol = 0; BNEcontrol = 1; end
            default: begin BEQcontrol = 0; BNEcontrol = 0; end
         endcase
         cyc("rand");
      end

      // illegal BEQ+BNE: taken and sticky error
      idle_inputs(); AluResult = 32'h55;
      cyc("err_tgt");
      BEQcontrol = 1; BNEcontrol = 1; PCSource = 1; AluZero = 1'($urandom);
      cyc("err_set");
      check("err_set.PC_const", 64'(PC), 64'h55);
      idle_inputs();
      for (int i = 0; i < 3; i++) cyc("err_hold");

      // asynchronous reset mid-branch
      AluResult = 32'h66;
      cyc("pre_reset");
      BEQcontrol = 1; AluZero = 1; PCSource = 1;
      #2 Reset = 1'b1;
      model_reset();
      #1;
      check_all("async_reset");
      check("async_reset.CtrlErr_const", 64'(CtrlErr), 64'h0);
      @(negedge Clk);
      Reset = 1'b0;
      idle_inputs(); AluResult = 32'h7;
      cyc("post_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
